modadd_operand_loader: RTL and testbench

Upstream/downstream wrapper for the 256-bit modular adder. It deserialises A, B and p from a 32-bit word stream into 256-bit operand registers and pulses the adder's start. It then captures the 256-bit result on the adder's done and serialises it back out as 32-bit words. It sits between the host/bus word interface and the modular adder core; the adder is instantiated alongside it in the parent, not inside it.

---
 rtl/modadd_operand_loader_pkg.sv | 17 +
 rtl/modadd_operand_loader_if.sv | 34 +++
 rtl/modadd_operand_loader_word_serializer.sv | 56 +++++
 rtl/modadd_operand_loader.sv | 95 +++++++++
 tb/tb_modadd_operand_loader.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/modadd_operand_loader_pkg.sv
// Shared constants and state encoding for the modular-adder operand loader.
package mod_pkg;
    localparam int MOD_OPERAND_W = 256;
    localparam int MOD_WORD_W    = 32;
    localparam int MOD_WORDS     = MOD_OPERAND_W / MOD_WORD_W;

    // Word-count widths for the default geometry (3 operands in, 1 result out)
    localparam int LD_CNT_W = $clog2(3 * MOD_WORDS);
    localparam int LD_IDX_W = (MOD_WORDS > 1) ? $clog2(MOD_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_UNLOAD
    } ld_state_e;
endpackage

// File: rtl/modadd_operand_loader_if.sv
// Word-stream, adder-side and result-stream signals of the operand loader.
interface modadd_operand_loader_if
    import mod_pkg::*;
#(
    parameter int OPERAND_W = MOD_OPERAND_W,
    parameter int WORD_W    = MOD_WORD_W
);
    logic                 i_wr_valid;
    logic                 o_wr_ready;
    logic [WORD_W-1:0]    i_wr_data;
    logic                 o_start;
    logic [OPERAND_W-1:0] o_a;
    logic [OPERAND_W-1:0] o_b;
    logic [OPERAND_W-1:0] o_p;
    logic                 i_done;
    logic [OPERAND_W-1:0] i_result;
    logic                 o_rd_valid;
    logic                 i_rd_ready;
    logic [WORD_W-1:0]    o_rd_data;
    logic                 o_rd_last;
    logic                 o_busy;

    modport slave (
        input  i_wr_valid, i_wr_data, i_done, i_result, i_rd_ready,
        output o_wr_ready, o_start, o_a, o_b, o_p,
               o_rd_valid, o_rd_data, o_rd_last, o_busy
    );

    modport master (
        output i_wr_valid, i_wr_data, i_done, i_result, i_rd_ready,
        input  o_wr_ready, o_start, o_a, o_b, o_p,
               o_rd_valid, o_rd_data, o_rd_last, o_busy
    );
endinterface

// File: rtl/modadd_operand_loader_word_serializer.sv
// Result register plus read index; emits the captured result LSW first under valid/ready.
module word_serializer
    import mod_pkg::*;
#(
    parameter int OPERAND_W = MOD_OPERAND_W,
    parameter int WORD_W    = MOD_WORD_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_flush,
    input  logic                 i_capture,
    input  logic [OPERAND_W-1:0] i_result,
    input  logic                 i_valid,
    input  logic                 i_ready,
    output logic [WORD_W-1:0]    o_data,
    output logic                 o_last,
    output logic                 o_last_hs
);
    localparam int WORDS = OPERAND_W / WORD_W;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [OPERAND_W-1:0] result_q;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [WORD_W-1:0]    data_q;
    logic                 last_q;
    logic                 hs;

    assign hs        = i_valid & i_ready;
    assign o_last_hs = hs & (idx_q == IDX_W'(WORDS - 1));
    assign idx_d     = o_last_hs ? '0 : idx_q + 1'b1;

    // Data/last are preloaded with the next word so they are registered yet ready on handshake
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            result_q <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
        end else if (i_flush) begin
            idx_q  <= '0;
            last_q <= 1'b0;
        end else if (i_capture) begin
            result_q <= i_result;
            idx_q    <= '0;
            data_q   <= i_result[WORD_W-1:0];
            last_q   <= (WORDS == 1);
        end else if (hs) begin
            idx_q  <= idx_d;
            data_q <= result_q[idx_d*WORD_W +: WORD_W];
            last_q <= !o_last_hs && (idx_d == IDX_W'(WORDS - 1));
        end
    end

    assign o_data = data_q;
    assign o_last = last_q;
endmodule

// File: rtl/modadd_operand_loader.sv
// Deserialises A, B, p into operand registers, starts the adder, and streams the result back.
module modadd_operand_loader
    import mod_pkg::*;
#(
    parameter int OPERAND_W = MOD_OPERAND_W,
    parameter int WORD_W    = MOD_WORD_W
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_flush,
    modadd_operand_loader_if.slave  bus
);
    localparam int WORDS = OPERAND_W / WORD_W;
    localparam int TOTAL = 3 * WORDS;
    localparam int CNT_W = $clog2(TOTAL);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    ld_state_e            state_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OPERAND_W-1:0] a_q, b_q, p_q;
    logic                 start_q;
    logic [1:0]           sel;
    logic [IDX_W-1:0]     widx;
    logic                 wr_hs;
    logic                 capture;
    logic                 last_hs;

    // Counter splits into operand select (A/B/p) and word slot within the operand
    assign sel     = 2'(cnt_q / CNT_W'(WORDS));
    assign widx    = IDX_W'(cnt_q % CNT_W'(WORDS));
    assign cnt_d   = cnt_q + 1'b1;
    assign wr_hs   = (state_q == ST_LOAD) & bus.i_wr_valid;
    assign capture = (state_q == ST_WAIT) & bus.i_done;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            start_q <= 1'b0;
        end else if (i_flush) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            start_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                ST_LOAD: if (wr_hs) begin
                    case (sel)
                        2'd0:    a_q[widx*WORD_W +: WORD_W] <= bus.i_wr_data;
                        2'd1:    b_q[widx*WORD_W +: WORD_W] <= bus.i_wr_data;
                        default: p_q[widx*WORD_W +: WORD_W] <= bus.i_wr_data;
                    endcase
                    if (cnt_q == CNT_W'(TOTAL - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_START;
                        start_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_START:  state_q <= ST_WAIT;
                ST_WAIT:   if (bus.i_done) state_q <= ST_UNLOAD;
                ST_UNLOAD: if (last_hs) state_q <= ST_LOAD;
                default:   state_q <= ST_LOAD;
            endcase
        end
    end

    word_serializer #(
        .OPERAND_W (OPERAND_W),
        .WORD_W    (WORD_W)
    ) u_ser (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_flush   (i_flush),
        .i_capture (capture),
        .i_result  (bus.i_result),
        .i_valid   (bus.o_rd_valid),
        .i_ready   (bus.i_rd_ready),
        .o_data    (bus.o_rd_data),
        .o_last    (bus.o_rd_last),
        .o_last_hs (last_hs)
    );

    assign bus.o_wr_ready = (state_q == ST_LOAD);
    assign bus.o_rd_valid = (state_q == ST_UNLOAD);
    assign bus.o_busy     = (state_q != ST_LOAD);
    assign bus.o_start    = start_q;
    assign bus.o_a        = a_q;
    assign bus.o_b        = b_q;
    assign bus.o_p        = p_q;
endmodule

// File: tb/tb_modadd_operand_loader.sv
// Directed table-driven bench for the modular-adder operand loader.
module tb_modadd_operand_loader;
    logic i_clk = 1'b0;
    logic i_rst;
    logic i_flush;

    modadd_operand_loader_if #(.OPERAND_W(256), .WORD_W(32)) bus();

    modadd_operand_loader #(.OPERAND_W(256), .WORD_W(32)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_flush),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [255:0] a, b, p, res;
        int ld_done_at;
        int stall_idx;
        int stall_n;
        int done_at;
    } vec_t;

    vec_t vecs[3];
    int checks = 0;
    int failures = 0;
    int start_cnt = 0;

    always @(negedge i_clk) if (bus.o_start === 1'b1) start_cnt++;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic load_words(input logic [255:0] a, b, p, input int from, input int to,
                              input int done_at);
        for (int k = from; k < to; k++) begin
            bus.i_wr_valid = 1'b1;
            if (k < 8)       bus.i_wr_data = a[k*32 +: 32];
            else if (k < 16) bus.i_wr_data = b[(k-8)*32 +: 32];
            else             bus.i_wr_data = p[(k-16)*32 +: 32];
            if (k == done_at) begin
                bus.i_done   = 1'b1;
                bus.i_result = '1;
            end
            tick();
            bus.i_done   = 1'b0;
            bus.i_result = '0;
            if (k == done_at && k != 23) begin
                chk("done_in_load_busy", bus.o_busy, 0);
                chk("done_in_load_wr_ready", bus.o_wr_ready, 1);
            end
        end
        bus.i_wr_valid = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_wr_ready", bus.o_wr_ready, 1);
        chk("rst_start", bus.o_start, 0);
        chk("rst_a", bus.o_a, 0);
        chk("rst_b", bus.o_b, 0);
        chk("rst_p", bus.o_p, 0);
        chk("rst_rd_valid", bus.o_rd_valid, 0);
        chk("rst_rd_data", bus.o_rd_data, 0);
        chk("rst_rd_last", bus.o_rd_last, 0);
        chk("rst_busy", bus.o_busy, 0);
    endtask

    task automatic run_vector(input vec_t v);
        int s0;
        logic [31:0] w;
        s0 = start_cnt;
        load_words(v.a, v.b, v.p, 0, 24, v.ld_done_at);
        chk("start_pulse", bus.o_start, 1);
        chk("busy_in_start", bus.o_busy, 1);
        chk("wr_ready_in_start", bus.o_wr_ready, 0);
        chk("op_a", bus.o_a, v.a);
        chk("op_b", bus.o_b, v.b);
        chk("op_p", bus.o_p, v.p);
        tick();
        chk("start_low_in_wait", bus.o_start, 0);
        repeat (2) tick();
        bus.i_done   = 1'b1;
        bus.i_result = v.res;
        chk("no_valid_before_done", bus.o_rd_valid, 0);
        tick();
        bus.i_done   = 1'b0;
        bus.i_result = '0;
        chk("start_count", 256'(start_cnt - s0), 1);
        chk("op_a_held", bus.o_a, v.a);
        for (int i = 0; i < 8; i++) begin
            w = v.res[i*32 +: 32];
            if (i == v.stall_idx) begin
                bus.i_rd_ready = 1'b0;
                for (int s = 0; s < v.stall_n; s++) begin
                    chk("stall_valid", bus.o_rd_valid, 1);
                    chk("stall_data", bus.o_rd_data, w);
                    chk("stall_last", bus.o_rd_last, 0);
                    tick();
                end
            end
            bus.i_rd_ready = 1'b1;
            if (i == v.done_at) begin
                bus.i_done   = 1'b1;
                bus.i_result = ~v.res;
            end
            chk("rd_valid", bus.o_rd_valid, 1);
            chk("rd_data", bus.o_rd_data, w);
            chk("rd_last", bus.o_rd_last, (i == 7));
            tick();
            bus.i_rd_ready = 1'b0;
            bus.i_done     = 1'b0;
            bus.i_result   = '0;
        end
        chk("post_unload_valid", bus.o_rd_valid, 0);
        chk("post_unload_busy", bus.o_busy, 0);
        chk("post_unload_wr_ready", bus.o_wr_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] r1, r2;
        int s0;
        for (int i = 0; i < 8; i++) begin
            r1[i*32 +: 32] = 32'hA000_0000 + 32'(i);
            r2[i*32 +: 32] = 32'h0BAD_0000 + 32'(i * 3);
        end
        vecs[0] = '{a: 256'd5, b: 256'd7, p: 256'd11, res: 256'd1,
                    ld_done_at: -1, stall_idx: -1, stall_n: 0, done_at: -1};
        vecs[1] = '{a: 256'd1 << 255, b: 256'hDEADBEEF,
                    p: 256'hFFFF_FFFF_0000_0001_1234_5678_9ABC_DEF0,
                    res: r1, ld_done_at: -1, stall_idx: 2, stall_n: 3, done_at: -1};
        vecs[2] = '{a: 256'h1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA,
                    b: 256'hCAFE_F00D, p: 256'hF0E1_D2C3_B4A5_9687_7869_5A4B_3C2D_1E0F_0102,
                    res: r2, ld_done_at: 5, stall_idx: -1, stall_n: 0, done_at: 4};

        i_rst = 1'b1;
        i_flush = 1'b0;
        bus.i_wr_valid = 1'b0;
        bus.i_wr_data  = '0;
        bus.i_done     = 1'b0;
        bus.i_result   = '0;
        bus.i_rd_ready = 1'b0;
        repeat (2) tick();
        check_reset_outputs();
        i_rst = 1'b0;
        tick();

        for (int v = 0; v < 3; v++) run_vector(vecs[v]);

        // Reset in the middle of a load, then a clean run
        load_words(vecs[1].a, vecs[1].b, vecs[1].p, 0, 10, -1);
        i_rst = 1'b1;
        #1;
        check_reset_outputs();
        tick();
        check_reset_outputs();
        i_rst = 1'b0;
        tick();
        run_vector(vecs[0]);

        // Flush while waiting for the adder; a later done must be ignored
        s0 = start_cnt;
        load_words(vecs[2].a, vecs[2].b, vecs[2].p, 0, 24, -1);
        tick();
        chk("flush_pre_busy", bus.o_busy, 1);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        chk("flush_wr_ready", bus.o_wr_ready, 1);
        chk("flush_busy", bus.o_busy, 0);
        chk("flush_rd_valid", bus.o_rd_valid, 0);
        chk("flush_start", bus.o_start, 0);
        chk("flush_keeps_a", bus.o_a, vecs[2].a);
        bus.i_done   = 1'b1;
        bus.i_result = '1;
        tick();
        bus.i_done   = 1'b0;
        bus.i_result = '0;
        chk("late_done_busy", bus.o_busy, 0);
        chk("late_done_rd_valid", bus.o_rd_valid, 0);
        tick();
        chk("late_done_rd_valid2", bus.o_rd_valid, 0);
        chk("flush_start_count", 256'(start_cnt - s0), 1);

        run_vector(vecs[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
